hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
// - Pipeline hazard controller; drives the freeze/bubble/flush controls consumed by PC, IF/ID, ID/EX and EX/MEM registers.
// - Registered FSM: load-use bubble insertion (multi-cycle capable), data-memory wait freeze with timeout, taken-branch IF/ID flush.
// - Sits in ID stage; outputs are Mealy (state + current inputs) so controls act in the same cycle the hazard is seen.
// PARAMETERS
// - LU_BUBBLES   1     bubbles inserted per load-use hazard (1..7)
// - MEM_TIMEOUT  255   max MEMWAIT cycles before abort (1..255)
// - CNT_W        32    perf counter width (HAZARD_PERF_EN only)
// PORTS
// - clk_i            in   1      clock, rising edge
// - rst_i            in   1      async reset, active-high
// - idex_memread_i   in   1      load in EX
// - idex_rtaddr_i    in   5      load destination in EX
// - ifid_rsaddr_i    in   5      rs of instr in ID
// - ifid_rtaddr_i    in   5      rt of instr in ID
// - ifid_uses_rt_i   in   1      instr in ID reads rt
// - branch_taken_i   in   1      branch resolved taken in ID
// - dmem_req_i       in   1      MEM stage access active
// - dmem_ack_i       in   1      data memory done
// - pc_write_o       out  1      PC load enable
// - ifid_write_o     out  1      IF/ID load enable
// - ifid_flush_o     out  1      IF/ID clear to NOP
// - idex_stall_o     out  1      ID/EX hold (to its stall input)
// - idex_bubble_o    out  1      ID/EX load zeroed controls
// - exmem_stall_o    out  1      EX/MEM and MEM/WB hold
// - err_o            out  1      sticky memory timeout flag
// BEHAVIOUR
// - States: RUN, LOADUSE, MEMWAIT. Reset (async): state=RUN, bubble cnt=0, wait cnt=0, err_o=0.
// - While rst_i=1: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_stall_o=0, idex_bubble_o=1, exmem_stall_o=0.
// - Defaults (RUN, no hazard): pc_write=1, ifid_write=1, all others 0.
// - lu_hit = idex_memread_i & rt!=0 & (rt==ifid_rs | (ifid_uses_rt_i & rt==ifid_rt)).
// - Priority per cycle: mem freeze > load-use > branch flush.
// - RUN: dmem_req_i&~dmem_ack_i -> MEMWAIT, this cycle pc_write=ifid_write=0, idex_stall=1, exmem_stall=1.
//   else lu_hit -> pc_write=ifid_write=0, idex_bubble=1, flush ignored; if LU_BUBBLES>1 -> LOADUSE, cnt=LU_BUBBLES-1.
//   else branch_taken_i -> ifid_flush=1 (PC still writes target).
// - LOADUSE: pc_write=ifid_write=0, idex_bubble=1; cnt-- ; cnt==1 at edge -> RUN. Mem freeze preempts: -> MEMWAIT, cnt kept, resume LOADUSE after ack.
// - MEMWAIT: full freeze (as above) while ~dmem_ack_i; wait cnt++. Ack cycle: freeze released same cycle, -> RUN (or LOADUSE if cnt!=0).
// - Wait cnt reaching MEM_TIMEOUT: err_o<=1 (sticky until reset), release freeze, -> RUN.
// - dmem_req_i and dmem_ack_i both 1 in RUN: no freeze.
// - Reset mid-stall: immediate RUN, counters cleared, err_o cleared.
// CONFIGURATION
// - HAZARD_PERF_EN defined: adds outputs stall_cnt_o, bubble_cnt_o, flush_cnt_o [CNT_W-1:0]; +1 per cycle of exmem_stall_o / idex_bubble_o / ifid_flush_o; saturate at all-ones; reset 0.
// - Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
// - Shared package cpu_pkg: state encodings (RUN=2'd0, LOADUSE=2'd1, MEMWAIT=2'd2), REG_ZERO=5'd0.
// - Sub-module sat_counter (CNT_W, inc_i, cnt_o), instantiated 3x under HAZARD_PERF_EN.
// TESTING
// - lw $2 in EX, ID add rs=$2, LU_BUBBLES=1 -> 1 cycle pc_write=0, idex_bubble=1; next cycle defaults.
// - Load rt=$0 with ID rs=$0 -> no bubble; load rt=$5, ID rt=$5, ifid_uses_rt=0 -> no bubble.
// - LU_BUBBLES=3, lu_hit -> exactly 3 bubble cycles, then RUN.
// - lu_hit and branch_taken same cycle -> ifid_flush_o=0, idex_bubble_o=1.
// - dmem_req=1, ack after 4 cycles -> exmem_stall=1 for 4 cycles, 0 on ack cycle; MEM_TIMEOUT=8 no ack -> err_o=1 after 8, freeze drops.
// - rst_i pulsed mid-MEMWAIT -> state RUN, err_o=0, reset output values during pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: hazard FSM state encodings and the register-zero constant,
// plus the load-use hazard detection helper used by the ID-stage hazard controller.
package cpu_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LOADUSE = 2'd1,
      MEMWAIT = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A load into $0 never produces a hazard since $0 always reads as zero.
   function automatic logic lu_hazard(input logic       memread,
                                      input logic [4:0] ex_rt,
                                      input logic [4:0] id_rs,
                                      input logic [4:0] id_rt,
                                      input logic       uses_rt);
      return memread && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the optional hazard performance counters.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage pipeline hazard controller: load-use bubbles, data-memory wait freeze with timeout,
// taken-branch IF/ID flush. Define HAZARD_PERF_EN to add saturating stall/bubble/flush counters.
module hazard_stall_ctrl
   import cpu_pkg::*;
#(
   parameter int LU_BUBBLES  = 1,
   parameter int MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
   ,
   parameter int CNT_W       = 32
`endif
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       idex_memread_i,
   input  logic [4:0] idex_rtaddr_i,
   input  logic [4:0] ifid_rsaddr_i,
   input  logic [4:0] ifid_rtaddr_i,
   input  logic       ifid_uses_rt_i,
   input  logic       branch_taken_i,
   input  logic       dmem_req_i,
   input  logic       dmem_ack_i,
   output logic       pc_write_o,
   output logic       ifid_write_o,
   output logic       ifid_flush_o,
   output logic       idex_stall_o,
   output logic       idex_bubble_o,
   output logic       exmem_stall_o,
   output logic       err_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] bubble_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
`endif
);

   localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);
   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   hz_state_e  state_q, state_d;
   logic [2:0] bub_cnt_q, bub_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       err_q, err_d;

   logic mem_freeze, lu_hit, timeout, resume_lu;

   assign mem_freeze = dmem_req_i && !dmem_ack_i;
   assign lu_hit     = lu_hazard(idex_memread_i, idex_rtaddr_i, ifid_rsaddr_i,
                                 ifid_rtaddr_i, ifid_uses_rt_i);
   assign timeout    = (wait_cnt_q >= TIMEOUT);
   assign resume_lu  = dmem_ack_i && (bub_cnt_q != 3'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         bub_cnt_q  <= 3'd0;
         wait_cnt_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bub_cnt_q  <= bub_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bub_cnt_d  = bub_cnt_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      unique case (state_q)
         RUN: begin
            if (mem_freeze) begin
               state_d    = MEMWAIT;
               wait_cnt_d = 8'd1;
            end else if (lu_hit && (LU_BUBBLES > 1)) begin
               state_d   = LOADUSE;
               bub_cnt_d = LU_INIT;
            end
         end
         LOADUSE: begin
            if (mem_freeze) begin
               state_d    = MEMWAIT;
               wait_cnt_d = 8'd1;
            end else if (bub_cnt_q <= 3'd1) begin
               state_d   = RUN;
               bub_cnt_d = 3'd0;
            end else begin
               bub_cnt_d = bub_cnt_q - 3'd1;
            end
         end
         MEMWAIT: begin
            // A timeout aborts the access and drops any pending bubbles; the ID instruction is re-examined.
            if (dmem_ack_i || timeout) begin
               wait_cnt_d = 8'd0;
               if (!dmem_ack_i) begin
                  err_d     = 1'b1;
                  bub_cnt_d = 3'd0;
               end
               if (resume_lu) begin
                  state_d = LOADUSE;
               end else if (lu_hit && (LU_BUBBLES > 1)) begin
                  state_d   = LOADUSE;
                  bub_cnt_d = LU_INIT;
               end else begin
                  state_d = RUN;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_stall_o  = 1'b0;
      idex_bubble_o = 1'b0;
      exmem_stall_o = 1'b0;
      if (rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (mem_freeze) begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_stall_o  = 1'b1;
                  exmem_stall_o = 1'b1;
               end else if (lu_hit) begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_bubble_o = 1'b1;
               end else if (branch_taken_i) begin
                  ifid_flush_o = 1'b1;
               end
            end
            LOADUSE: begin
               pc_write_o   = 1'b0;
               ifid_write_o = 1'b0;
               if (mem_freeze) begin
                  idex_stall_o  = 1'b1;
                  exmem_stall_o = 1'b1;
               end else begin
                  idex_bubble_o = 1'b1;
               end
            end
            MEMWAIT: begin
               if (dmem_ack_i || timeout) begin
                  if (resume_lu || lu_hit) begin
                     pc_write_o    = 1'b0;
                     ifid_write_o  = 1'b0;
                     idex_bubble_o = 1'b1;
                  end else if (branch_taken_i) begin
                     ifid_flush_o = 1'b1;
                  end
               end else begin
                  pc_write_o    = 1'b0;
                  ifid_write_o  = 1'b0;
                  idex_stall_o  = 1'b1;
                  exmem_stall_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign err_o = err_q;

`ifdef HAZARD_PERF_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (exmem_stall_o),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (idex_bubble_o),
      .cnt_o (bubble_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (ifid_flush_o),
      .cnt_o (flush_cnt_o)
   );
`else
   // Core-only build: no performance counters.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: two instances (1 and 3 load-use bubbles, 8-cycle memory timeout)
// share one stimulus stream; expected outputs go through a scoreboard queue.
module tb_hazard_stall_ctrl;

   // Output vector layout: {pc_write, ifid_write, ifid_flush, idex_stall, idex_bubble, exmem_stall, err}
   localparam logic [6:0] DEF    = 7'b1100000;
   localparam logic [6:0] BUB    = 7'b0000100;
   localparam logic [6:0] FLU    = 7'b1110000;
   localparam logic [6:0] FRZ    = 7'b0001010;
   localparam logic [6:0] RSTV   = 7'b0010100;
   localparam logic [6:0] DEFERR = 7'b1100001;
   localparam logic [6:0] FRZERR = 7'b0001011;

   logic       clk = 1'b0;
   logic       rst;
   logic       memread, uses_rt, br, req, ack;
   logic [4:0] ex_rt, id_rs, id_rt;

   logic pc1, ifw1, fl1, st1, bu1, ex1, er1;
   logic pc3, ifw3, fl3, st3, bu3, ex3, er3;
   logic [6:0] out1, out3;

`ifdef HAZARD_PERF_EN
   logic [31:0] sc1, bc1, fc1, sc3, bc3, fc3;
`endif

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(8)) dut1 (
      .clk_i          (clk),
      .rst_i          (rst),
      .idex_memread_i (memread),
      .idex_rtaddr_i  (ex_rt),
      .ifid_rsaddr_i  (id_rs),
      .ifid_rtaddr_i  (id_rt),
      .ifid_uses_rt_i (uses_rt),
      .branch_taken_i (br),
      .dmem_req_i     (req),
      .dmem_ack_i     (ack),
      .pc_write_o     (pc1),
      .ifid_write_o   (ifw1),
      .ifid_flush_o   (fl1),
      .idex_stall_o   (st1),
      .idex_bubble_o  (bu1),
      .exmem_stall_o  (ex1),
      .err_o          (er1)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt_o    (sc1),
      .bubble_cnt_o   (bc1),
      .flush_cnt_o    (fc1)
`endif
   );

   hazard_stall_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(8)) dut3 (
      .clk_i          (clk),
      .rst_i          (rst),
      .idex_memread_i (memread),
      .idex_rtaddr_i  (ex_rt),
      .ifid_rsaddr_i  (id_rs),
      .ifid_rtaddr_i  (id_rt),
      .ifid_uses_rt_i (uses_rt),
      .branch_taken_i (br),
      .dmem_req_i     (req),
      .dmem_ack_i     (ack),
      .pc_write_o     (pc3),
      .ifid_write_o   (ifw3),
      .ifid_flush_o   (fl3),
      .idex_stall_o   (st3),
      .idex_bubble_o  (bu3),
      .exmem_stall_o  (ex3),
      .err_o          (er3)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt_o    (sc3),
      .bubble_cnt_o   (bc3),
      .flush_cnt_o    (fc3)
`endif
   );

   assign out1 = {pc1, ifw1, fl1, st1, bu1, ex1, er1};
   assign out3 = {pc3, ifw3, fl3, st3, bu3, ex3, er3};

   typedef struct {
      logic       memread;
      logic [4:0] ex_rt;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       uses_rt;
      logic       br;
      logic       req;
      logic       ack;
      logic [6:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      string      name;
      int         sel;
      logic [6:0] exp;
   } sb_t;

   sb_t  sbq[$];
   vec_t tbl[11];
   int   compared   = 0;
   int   mismatched = 0;

   // Pop the oldest expectation and compare it against the selected instance.
   task automatic checkOutput();
      sb_t        e;
      logic [6:0] act;
      compared++;
      if (sbq.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_empty: got no entry, required one entry");
         return;
      end
      e   = sbq.pop_front();
      act = (e.sel == 3) ? out3 : out1;
      if (act !== e.exp) begin
         mismatched++;
         $display("[TB] FAIL %s (dut%0d): got %b required %b", e.name, e.sel, act, e.exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, record the expectation, check at the falling edge.
   task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] ert,
                                input logic [4:0] irs, input logic [4:0] irt, input logic urt,
                                input logic b, input logic rq, input logic ak,
                                input int sel, input logic [6:0] exp, input string name);
      sb_t e;
      @(posedge clk);
      #1;
      rst     = r;
      memread = mr;
      ex_rt   = ert;
      id_rs   = irs;
      id_rt   = irt;
      uses_rt = urt;
      br      = b;
      req     = rq;
      ack     = ak;
      e.name  = name;
      e.sel   = sel;
      e.exp   = exp;
      sbq.push_back(e);
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      rst = 1'b1; memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
      uses_rt = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;

      tbl[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF, "idle"};
      tbl[1]  = '{1'b1, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, BUB, "lu_rs_hit"};
      tbl[2]  = '{1'b0, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, DEF, "after_bubble"};
      tbl[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF, "lu_reg_zero"};
      tbl[4]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, DEF, "lu_rt_unused"};
      tbl[5]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, BUB, "lu_rt_used"};
      tbl[6]  = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, DEF, "no_load_match"};
      tbl[7]  = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, FLU, "branch_flush"};
      tbl[8]  = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BUB, "lu_over_branch"};
      tbl[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, DEF, "req_ack_same"};
      tbl[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, FLU, "req_ack_branch"};

      $display("[TB] reset checks");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RSTV, "reset_out");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, RSTV, "reset_out");

      $display("[TB] single-cycle vector table");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(0, tbl[i].memread, tbl[i].ex_rt, tbl[i].id_rs, tbl[i].id_rt,
                       tbl[i].uses_rt, tbl[i].br, tbl[i].req, tbl[i].ack, 1, tbl[i].exp, tbl[i].name);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, "drain");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, DEF, "drain3");

      $display("[TB] three-bubble load-use");
      applyStimulus(0, 1, 2, 2, 0, 0, 0, 0, 0, 3, BUB, "lu3_b1");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, BUB, "lu3_b2");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, BUB, "lu3_b3_no_flush");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, DEF, "lu3_done");

      $display("[TB] memory wait with ack after 4 cycles");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, FRZ, "mw_c1_over_branch");
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ, "mw_freeze");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, DEF, "mw_ack_release");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, "mw_after");

      $display("[TB] memory timeout");
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ, "to_freeze");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, DEF, "to_release");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEFERR, "to_err_set");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEFERR, "to_err_sticky");

      $display("[TB] reset mid memory wait");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZERR, "pre_rst_freeze");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZERR, "pre_rst_freeze2");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, RSTV, "mid_rst_out");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, "post_rst_run");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
